rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Writer-side front end for the 32x32 register file.
- Collects results from three producers and serialises them onto the file's single write port (wen / waddr / wdata):
  - single-cycle ALU
  - load unit (LSU)
  - multi-cycle mul/div unit (MDU)
- Holds a 32-entry pending scoreboard so the issue stage can stall on registers still awaiting a long-latency result.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- XLEN, 32, data width
- FIFO_DEPTH, 2, entries per long-latency source FIFO (power of two, >=2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result valid this cycle (no back-pressure)
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  load result offered
- lsu_ready  out  1  load FIFO can accept
- lsu_rd  in  5  load destination
- lsu_data  in  XLEN  load data
- mdu_valid  in  1  mul/div result offered
- mdu_ready  out  1  MDU FIFO can accept
- mdu_rd  in  5  MDU destination
- mdu_data  in  XLEN  MDU result
- sb_set  in  1  issue stage dispatched a load/MDU op
- sb_set_rd  in  5  its destination
- sb_raddr1  in  5  scoreboard query address 1
- sb_raddr2  in  5  scoreboard query address 2
- sb_busy1  out  1  pending[sb_raddr1]
- sb_busy2  out  1  pending[sb_raddr2]
- rf_wen  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  XLEN  register file write data

Behaviour:

Reset (synchronous):
- rf_wen=0, rf_waddr=0, rf_wdata=0.
- Both FIFOs empty; all pending bits 0; round-robin pointer = LSU.
- Reset mid-operation discards all queued results and pending bits, with no write in the following cycle.

Input handshake:
- LSU/MDU transfer occurs when valid&ready.
- ready = FIFO not full. It is a registered-state function and must not depend on valid.
- A transfer with rd=0 is accepted and discarded: not enqueued, no write.
- A full FIFO may not accept a push in the same cycle it pops. ready stays low while full.

Arbitration, evaluated each cycle, with one winner per cycle:
- If alu_valid && alu_rd!=0: ALU wins. The ALU is never stalled.
- Otherwise, among non-empty FIFOs, round-robin between LSU and MDU:
  - Grant the one the pointer names if it is non-empty, else the other.
  - After a FIFO grant, the pointer moves to the other source.
- No candidate: no write.
- An entry pushed in cycle N is eligible from cycle N+1, never in the same cycle.

Output timing:
- rf_wen/rf_waddr/rf_wdata are registered: the winner in cycle N appears at the outputs in cycle N+1 for exactly one cycle.
- ALU latency is 1 cycle. FIFO-path minimum latency is 2 cycles.
- When rf_wen=0, rf_waddr and rf_wdata hold their previous values.
- rf_waddr is never 0 while rf_wen=1.

Scoreboard:
- sb_set with sb_set_rd!=0 sets pending[sb_set_rd] at the clock edge. sb_set with rd 0 is ignored.
- A FIFO-sourced grant clears pending[rd] at the same edge that loads rf_wen=1. ALU writes never clear pending bits.
- Same-edge set and clear on the same rd: set wins.
- sb_busy1/sb_busy2 are combinational reads of pending. Address 0 always reads 0.
- Busy drops in the same cycle rf_wen is asserted for that rd. The register file's write-first bypass makes the value visible in that cycle.

Ordering:
- Each FIFO is strict FIFO order.
- No ordering is guaranteed between LSU and MDU. The issue stage prevents WAW hazards using sb_busy.

Test Plan:
- Reset, then alu_valid=1, rd=5, data=0xDEADBEEF at cycle 0 -> cycle 1 shows rf_wen=1, waddr=5, wdata=0xDEADBEEF; cycle 2 shows rf_wen=0.
- Push LSU rd=3 data=0x11 while ALU idle -> write appears 2 cycles after the handshake. Push two more with no pops -> lsu_ready=0 after the 2nd entry; the 3rd is held off until a pop.
- Continuous alu_valid for 5 cycles with an LSU entry queued -> no LSU write during the ALU run; the LSU write appears on the cycle after the run ends (starvation by ALU is allowed).
- LSU and MDU FIFOs each hold 2 entries, ALU idle -> writes alternate LSU, MDU, LSU, MDU over 4 consecutive cycles.
- sb_set rd=7, query raddr1=7 -> busy1=1. On the MDU rd=7 write cycle, busy1=0. Set and clear of rd=7 on the same edge -> busy1 stays 1.
- LSU rd=0 push and ALU rd=0 -> accepted and no rf_wen; sb_set rd=0 -> busy for 0 reads 0. Assert reset with full FIFOs -> no writes follow, and lsu_ready=mdu_ready=1 after reset.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU > round-robin(LSU, MDU) with a pending scoreboard.
// ALU 1-cycle, FIFO path >=2-cycle latency; LSU/MDU backpressured by FIFO-full only.

module rf_wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   output logic             push_rdy,
   output logic             pop_vld,
   output logic [WIDTH-1:0] pop_dat,
   input  logic             pop_rdy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push, pop;

   // Ready is a function of the registered count only, so a full FIFO
   // cannot take a push in the cycle it pops.
   assign push_rdy = (cnt_q != FULL_CNT);
   assign pop_vld  = (cnt_q != '0);
   assign pop_dat  = mem_q[rd_ptr_q];
   assign push     = push_vld && push_rdy;
   assign pop      = pop_rdy && pop_vld;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_dat;
      end
   end
endmodule

module rf_wb_arbiter #(
   parameter int XLEN       = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   input  logic            mdu_valid,
   output logic            mdu_ready,
   input  logic [4:0]      mdu_rd,
   input  logic [XLEN-1:0] mdu_data,
   input  logic            sb_set,
   input  logic [4:0]      sb_set_rd,
   input  logic [4:0]      sb_raddr1,
   input  logic [4:0]      sb_raddr2,
   output logic            sb_busy1,
   output logic            sb_busy2,
   output logic            rf_wen,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata
);
   localparam int EW = XLEN + 5;

   typedef enum logic {
      RR_LSU = 1'b0,
      RR_MDU = 1'b1
   } rr_e;

   rr_e             rr_q, rr_d;
   logic [31:0]     pending_q, pending_d;
   logic            rf_wen_q, rf_wen_d;
   logic [4:0]      rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

   logic            lsu_nempty, mdu_nempty;
   logic [EW-1:0]   lsu_head, mdu_head;
   logic            alu_win, lsu_gnt, mdu_gnt;
   logic [4:0]      fifo_rd;
   logic [XLEN-1:0] fifo_data;

   // rd=0 results are handshaked normally but never enter the FIFO.
   rf_wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_lsu_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (lsu_valid && (lsu_rd != 5'd0)),
      .push_dat ({lsu_rd, lsu_data}),
      .push_rdy (lsu_ready),
      .pop_vld  (lsu_nempty),
      .pop_dat  (lsu_head),
      .pop_rdy  (lsu_gnt)
   );

   rf_wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_mdu_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (mdu_valid && (mdu_rd != 5'd0)),
      .push_dat ({mdu_rd, mdu_data}),
      .push_rdy (mdu_ready),
      .pop_vld  (mdu_nempty),
      .pop_dat  (mdu_head),
      .pop_rdy  (mdu_gnt)
   );

   always_comb begin
      alu_win = alu_valid && (alu_rd != 5'd0);
      lsu_gnt = 1'b0;
      mdu_gnt = 1'b0;
      if (!alu_win) begin
         if (lsu_nempty && ((rr_q == RR_LSU) || !mdu_nempty)) begin
            lsu_gnt = 1'b1;
         end else if (mdu_nempty) begin
            mdu_gnt = 1'b1;
         end
      end
   end

   assign fifo_rd   = lsu_gnt ? lsu_head[EW-1 -: 5] : mdu_head[EW-1 -: 5];
   assign fifo_data = lsu_gnt ? lsu_head[XLEN-1:0] : mdu_head[XLEN-1:0];

   always_comb begin
      rr_d       = rr_q;
      pending_d  = pending_q;
      rf_wen_d   = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;

      if (alu_win) begin
         rf_wen_d   = 1'b1;
         rf_waddr_d = alu_rd;
         rf_wdata_d = alu_data;
      end else if (lsu_gnt || mdu_gnt) begin
         rf_wen_d           = 1'b1;
         rf_waddr_d         = fifo_rd;
         rf_wdata_d         = fifo_data;
         pending_d[fifo_rd] = 1'b0;
         rr_d               = lsu_gnt ? RR_MDU : RR_LSU;
      end

      // Applied after the clear so a same-edge set on the same rd wins.
      if (sb_set && (sb_set_rd != 5'd0)) begin
         pending_d[sb_set_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_q       <= RR_LSU;
         pending_q  <= '0;
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         rr_q       <= rr_d;
         pending_q  <= pending_d;
         rf_wen_q   <= rf_wen_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   // Bit 0 is never set, so queries of x0 always read not-busy.
   assign sb_busy1 = pending_q[sb_raddr1];
   assign sb_busy2 = pending_q[sb_raddr2];

   assign rf_wen   = rf_wen_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized + directed bench for rf_wb_arbiter: a queue-based reference model predicts each
// write (with its cycle), a monitor compares the DUT write port against those predictions.

module tb_rf_wb_arbiter;
   localparam int XLEN  = 32;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;
   logic            alu_valid, lsu_valid, mdu_valid, sb_set;
   logic [4:0]      alu_rd, lsu_rd, mdu_rd, sb_set_rd, sb_raddr1, sb_raddr2;
   logic [XLEN-1:0] alu_data, lsu_data, mdu_data;
   logic            lsu_ready, mdu_ready, sb_busy1, sb_busy2, rf_wen;
   logic [4:0]      rf_waddr;
   logic [XLEN-1:0] rf_wdata;

   rf_wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
      .sb_set(sb_set), .sb_set_rd(sb_set_rd), .sb_raddr1(sb_raddr1), .sb_raddr2(sb_raddr2),
      .sb_busy1(sb_busy1), .sb_busy2(sb_busy2),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   typedef struct {
      int          stamp;
      bit          rst;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   exp_t expq[$];
   ent_t lq[$];
   ent_t mq[$];
   bit   pend [32];
   bit   turn_mdu;
   int   pcyc = 0;
   int   compared = 0;
   int   mismatched = 0;

   // Staged stimulus, applied at the next falling edge.
   logic        d_rst, d_alu_v, d_lsu_v, d_mdu_v, d_set;
   logic [4:0]  d_alu_rd, d_lsu_rd, d_mdu_rd, d_set_rd, d_ra1, d_ra2;
   logic [31:0] d_alu_d, d_lsu_d, d_mdu_d;

   always @(posedge clk) pcyc <= pcyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, pcyc);
      end
   endtask

   task automatic idle_d();
      d_rst = 0; d_alu_v = 0; d_lsu_v = 0; d_mdu_v = 0; d_set = 0;
      d_alu_rd = 0; d_lsu_rd = 0; d_mdu_rd = 0; d_set_rd = 0; d_ra1 = 0; d_ra2 = 0;
      d_alu_d = 0; d_lsu_d = 0; d_mdu_d = 0;
   endtask

   task automatic push_write(input logic [4:0] a, input logic [31:0] d);
      exp_t e;
      e.stamp = pcyc + 1; e.rst = 1'b0; e.addr = a; e.data = d;
      expq.push_back(e);
   endtask

   // Reference model: one call per clock cycle, using the inputs being presented now.
   task automatic model();
      exp_t e;
      ent_t t;
      bit   lrdy, mrdy, pick_lsu;
      lrdy = (lq.size() < DEPTH);
      mrdy = (mq.size() < DEPTH);
      chk("lsu_ready", {31'b0, lsu_ready}, {31'b0, lrdy});
      chk("mdu_ready", {31'b0, mdu_ready}, {31'b0, mrdy});
      chk("sb_busy1", {31'b0, sb_busy1}, {31'b0, (sb_raddr1 != 0) && pend[sb_raddr1]});
      chk("sb_busy2", {31'b0, sb_busy2}, {31'b0, (sb_raddr2 != 0) && pend[sb_raddr2]});
      if (reset) begin
         lq.delete();
         mq.delete();
         foreach (pend[i]) pend[i] = 1'b0;
         turn_mdu = 1'b0;
         e.stamp = pcyc + 1; e.rst = 1'b1; e.addr = 0; e.data = 0;
         expq.push_back(e);
      end else begin
         if (alu_valid && alu_rd != 0) begin
            push_write(alu_rd, alu_data);
         end else if (lq.size() > 0 || mq.size() > 0) begin
            pick_lsu = (lq.size() > 0) && (!turn_mdu || mq.size() == 0);
            if (pick_lsu) t = lq.pop_front();
            else          t = mq.pop_front();
            turn_mdu = pick_lsu;
            pend[t.rd] = 1'b0;
            push_write(t.rd, t.data);
         end
         if (sb_set && sb_set_rd != 0) pend[sb_set_rd] = 1'b1;
         if (lsu_valid && lrdy && lsu_rd != 0) begin
            t.rd = lsu_rd; t.data = lsu_data; lq.push_back(t);
         end
         if (mdu_valid && mrdy && mdu_rd != 0) begin
            t.rd = mdu_rd; t.data = mdu_data; mq.push_back(t);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      reset = d_rst;
      alu_valid = d_alu_v; alu_rd = d_alu_rd; alu_data = d_alu_d;
      lsu_valid = d_lsu_v; lsu_rd = d_lsu_rd; lsu_data = d_lsu_d;
      mdu_valid = d_mdu_v; mdu_rd = d_mdu_rd; mdu_data = d_mdu_d;
      sb_set = d_set; sb_set_rd = d_set_rd; sb_raddr1 = d_ra1; sb_raddr2 = d_ra2;
      #1;
      model();
   endtask

   // Monitor: every cycle the write port must match the prediction stamped for it,
   // and address/data must hold their last written value when idle.
   initial begin : monitor
      exp_t        e;
      bit          exp_wen;
      logic [4:0]  ha;
      logic [31:0] hd;
      ha = 0; hd = 0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_wen = 1'b0;
         if (expq.size() > 0 && expq[0].stamp == pcyc) begin
            e = expq.pop_front();
            if (e.rst) begin
               ha = 0; hd = 0;
            end else begin
               exp_wen = 1'b1; ha = e.addr; hd = e.data;
            end
         end
         chk("rf_wen", {31'b0, rf_wen}, {31'b0, exp_wen});
         chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, ha});
         chk("rf_wdata", rf_wdata, hd);
      end
   end

   initial begin : driver
      reset = 1; alu_valid = 0; lsu_valid = 0; mdu_valid = 0; sb_set = 0;
      alu_rd = 0; lsu_rd = 0; mdu_rd = 0; sb_set_rd = 0; sb_raddr1 = 0; sb_raddr2 = 0;
      alu_data = 0; lsu_data = 0; mdu_data = 0;
      turn_mdu = 0;
      foreach (pend[i]) pend[i] = 1'b0;
      idle_d();
      repeat (2) @(posedge clk);

      // ALU single write
      d_alu_v = 1; d_alu_rd = 5; d_alu_d = 32'hDEADBEEF; tick();
      idle_d(); repeat (2) tick();

      // LSU single write, 2-cycle latency
      d_lsu_v = 1; d_lsu_rd = 3; d_lsu_d = 32'h11; tick();
      idle_d(); repeat (3) tick();

      // ALU run of 5 starves the LSU; LSU fills, third entry held off until a pop
      for (int i = 0; i < 8; i++) begin
         d_alu_v = (i < 5); d_alu_rd = 1; d_alu_d = 32'h100 + i;
         d_lsu_v = (i < 7); d_lsu_rd = (i < 2) ? 5'(10 + i) : 5'd12; d_lsu_d = 32'h200 + ((i < 2) ? i : 2);
         tick();
      end
      idle_d(); repeat (5) tick();

      // Fill both FIFOs behind the ALU, then watch them alternate
      for (int i = 0; i < 3; i++) begin
         d_alu_v = 1; d_alu_rd = 2; d_alu_d = 32'h300 + i;
         d_lsu_v = (i < 2); d_lsu_rd = 5'(20 + i); d_lsu_d = 32'h400 + i;
         d_mdu_v = (i < 2); d_mdu_rd = 5'(24 + i); d_mdu_d = 32'h500 + i;
         tick();
      end
      idle_d(); repeat (6) tick();

      // Scoreboard set, clear by MDU write, then same-edge set/clear
      d_ra1 = 7; d_set = 1; d_set_rd = 7; tick();
      d_set = 0; tick();
      d_mdu_v = 1; d_mdu_rd = 7; d_mdu_d = 32'h77; tick();
      d_mdu_v = 0; repeat (3) tick();
      d_set = 1; tick();
      d_set = 0; d_mdu_v = 1; d_mdu_d = 32'h78; tick();
      d_mdu_v = 0; d_set = 1; tick();
      d_set = 0; repeat (3) tick();

      // rd = 0 everywhere
      idle_d();
      d_lsu_v = 1; d_alu_v = 1; d_mdu_v = 1; d_set = 1; d_alu_d = 32'hBAD; d_lsu_d = 32'hBAD;
      tick();
      idle_d(); repeat (3) tick();

      // Reset with full FIFOs and pending bits
      for (int i = 0; i < 3; i++) begin
         d_alu_v = 1; d_alu_rd = 9; d_alu_d = 32'h600 + i;
         d_lsu_v = 1; d_lsu_rd = 5'(13 + i); d_lsu_d = 32'h700 + i;
         d_mdu_v = 1; d_mdu_rd = 5'(16 + i); d_mdu_d = 32'h800 + i;
         d_set = 1; d_set_rd = 5'(13 + i); d_ra1 = 13; d_ra2 = 16;
         tick();
      end
      idle_d(); d_rst = 1; tick();
      d_rst = 0; d_ra1 = 13; d_ra2 = 16; repeat (4) tick();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         d_rst    = ($urandom_range(0, 299) == 0);
         d_alu_v  = ($urandom_range(0, 9) < 3);
         d_alu_rd = 5'($urandom_range(0, 31)); d_alu_d = $urandom;
         d_lsu_v  = ($urandom_range(0, 1) == 1);
         d_lsu_rd = 5'($urandom_range(0, 31)); d_lsu_d = $urandom;
         d_mdu_v  = ($urandom_range(0, 2) == 0);
         d_mdu_rd = 5'($urandom_range(0, 31)); d_mdu_d = $urandom;
         d_set    = ($urandom_range(0, 2) == 0);
         d_set_rd = 5'($urandom_range(0, 31));
         d_ra1    = 5'($urandom_range(0, 31)); d_ra2 = 5'($urandom_range(0, 31));
         tick();
      end
      idle_d(); repeat (10) tick();

      chk("drain", expq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
